// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@72 timing constants, coordinate width and axis phase type
package vga_pkg;
  localparam int COORD_W  = 11;
  localparam int CLK_DIV_D = 2;
  localparam int H_SYNC_D = 120;
  localparam int H_BP_D   = 64;
  localparam int H_ACT_D  = 800;
  localparam int H_FP_D   = 56;
  localparam int V_SYNC_D = 6;
  localparam int V_BP_D   = 23;
  localparam int V_ACT_D  = 600;
  localparam int V_FP_D   = 37;
  typedef enum logic [1:0] {SYNC, BP, ACT, FP} phase_t;
endpackage

// File: rtl/vga_axis_ctr.sv
// vga_axis_ctr: one raster axis -- position counter with sync/bp/act/fp phase tracking
module vga_axis_ctr import vga_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic [COORD_W-1:0] sync_len,
  input  logic [COORD_W-1:0] bp_len,
  input  logic [COORD_W-1:0] act_len,
  input  logic [COORD_W-1:0] fp_len,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync,
  output logic               active
);
  phase_t             phase, ph_n;
  logic [COORD_W-1:0] total, nxt;
  assign total = sync_len + bp_len + act_len + fp_len;
  assign wrap  = count == total - 1'b1;
  // next position and the phase it falls in; phases change only on boundary crossings
  always_comb begin
    nxt  = !step ? count : wrap ? '0 : count + 1'b1;
    ph_n = nxt == '0                          ? SYNC :
           nxt == sync_len                    ? BP   :
           nxt == sync_len + bp_len           ? ACT  :
           nxt == sync_len + bp_len + act_len ? FP   : phase;
  end
  // count, phase FSM and its decoded flags all update together so they describe the same position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      phase  <= SYNC;
      sync   <= 1'b1;
      active <= 1'b0;
    end else begin
      count  <= nxt;
      phase  <= ph_n;
      sync   <= ph_n == SYNC;
      active <= ph_n == ACT;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel divider plus horizontal/vertical axes producing VGA sync, coordinates and strobes
module vga_timing_gen import vga_pkg::*; #(
  parameter int   CLK_DIV = CLK_DIV_D,
  parameter int   H_SYNC  = H_SYNC_D,
  parameter int   H_BP    = H_BP_D,
  parameter int   H_ACT   = H_ACT_D,
  parameter int   H_FP    = H_FP_D,
  parameter int   V_SYNC  = V_SYNC_D,
  parameter int   V_BP    = V_BP_D,
  parameter int   V_ACT   = V_ACT_D,
  parameter int   V_FP    = V_FP_D,
  parameter logic HS_POL  = 1'b1,
  parameter logic VS_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               pix_en,
  output logic [COORD_W-1:0] hc,
  output logic [COORD_W-1:0] vc,
  output logic               vidon,
  output logic               hsync,
  output logic               vsync,
  output logic               line_tick,
  output logic               frame_tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] d;
  logic h_wrap, v_wrap, h_sync, v_sync, h_act, v_act, v_step;
  assign pix_en = rst_n && en && d == DW'(CLK_DIV - 1);
  assign v_step = pix_en && h_wrap;
  assign hsync  = h_sync ? HS_POL : !HS_POL;
  assign vsync  = v_sync ? VS_POL : !VS_POL;
  assign vidon  = h_act && v_act;
  // pixel divider and line/frame strobes; ticks are high in the first cycle at the wrapped position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d          <= '0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      d          <= !en ? d : pix_en ? '0 : d + 1'b1;
      line_tick  <= v_step;
      frame_tick <= v_step && v_wrap;
    end
  end
  vga_axis_ctr u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_en),
    .sync_len(COORD_W'(H_SYNC)), .bp_len(COORD_W'(H_BP)),
    .act_len(COORD_W'(H_ACT)), .fp_len(COORD_W'(H_FP)),
    .count(hc), .wrap(h_wrap), .sync(h_sync), .active(h_act)
  );
  vga_axis_ctr u_v (
    .clk(clk), .rst_n(rst_n), .step(v_step),
    .sync_len(COORD_W'(V_SYNC)), .bp_len(COORD_W'(V_BP)),
    .act_len(COORD_W'(V_ACT)), .fp_len(COORD_W'(V_FP)),
    .count(vc), .wrap(v_wrap), .sync(v_sync), .active(v_act)
  );
endmodule
